// File: rtl/div_pkg.sv
// Shared types and defaults for the programmable clock divider.
// Holds the controller state encoding and the default sizing constants.
package div_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   localparam int          DIV_WIDTH   = 32;
   localparam int unsigned DIV_DEFAULT = 355500;

endpackage

// File: rtl/div_counter.sv
// Half-period counter with registered divided clock output.
// wrap marks the cycle whose rising edge resets the count and toggles clk_out.
module div_counter
   import div_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [WIDTH-1:0] div,
   output logic             wrap,
   output logic             clk_out
);

   logic [WIDTH-1:0] cnt;

   assign wrap = en && (cnt == div - WIDTH'(1));

   // Dropping en parks the divider low with a cleared count.
   always_ff @(posedge clk) begin
      if (rst || !en) begin
         cnt     <= '0;
         clk_out <= 1'b0;
      end else if (wrap) begin
         cnt     <= '0;
         clk_out <= ~clk_out;
      end else begin
         cnt     <= cnt + WIDTH'(1);
      end
   end

endmodule

// File: rtl/clk_div_ctrl.sv
// Run/stop controller and divisor configuration for div_counter.
// Divisor changes only ever take effect on a half-period boundary.
module clk_div_ctrl
   import div_pkg::*;
#(
   parameter int          WIDTH       = DIV_WIDTH,
   parameter int unsigned DEFAULT_DIV = DIV_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             stop,
   input  logic             cfg_valid,
   input  logic [WIDTH-1:0] cfg_div,
   output logic             cfg_ready,
   output logic             cfg_err,
   output logic             clk_out,
   output logic             tick,
   output logic             busy,
   output logic [WIDTH-1:0] cur_div
);

   if (DEFAULT_DIV == 0) begin : g_bad_default
      $fatal(1, "clk_div_ctrl: DEFAULT_DIV must be nonzero");
   end

   state_t           state;
   state_t           state_nxt;
   logic             en;
   logic             wrap;
   logic             run_req;
   logic             pend_v;
   logic [WIDTH-1:0] pend;
   logic             xfer;
   logic             xfer_ok;
   logic             xfer_bad;
   logic             direct;
   logic             apply;

   assign run_req   = start && !stop;
   assign cfg_ready = !pend_v;
   assign busy      = (state != IDLE);

   assign xfer     = cfg_valid && cfg_ready;
   assign xfer_bad = xfer && (cfg_div == '0);
   assign xfer_ok  = xfer && (cfg_div != '0);

   // When the divider is (or is about to be) idle there is nothing to
   // protect, so an accepted divisor goes straight into cur_div.
   assign direct = (state == IDLE) || (state_nxt == IDLE);
   assign apply  = pend_v && (wrap || state_nxt == IDLE);

   div_counter #(
      .WIDTH   (WIDTH)
   ) u_cnt (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .div     (cur_div),
      .wrap    (wrap),
      .clk_out (clk_out)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // A stop while high waits for the falling toggle, unless this
   // very cycle is that toggle.
   always_comb begin
      state_nxt = state;
      en        = 1'b0;
      unique case (state)
         IDLE: begin
            if (run_req) begin
               state_nxt = RUN;
            end
         end
         RUN: begin
            en = !(stop && !clk_out);
            if (stop) begin
               state_nxt = (clk_out && !wrap) ? DRAIN : IDLE;
            end
         end
         DRAIN: begin
            en = 1'b1;
            if (run_req) begin
               state_nxt = RUN;
            end else if (wrap) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tick    <= 1'b0;
         cfg_err <= 1'b0;
         cur_div <= WIDTH'(DEFAULT_DIV);
         pend    <= '0;
         pend_v  <= 1'b0;
      end else begin
         tick    <= wrap;
         cfg_err <= xfer_bad;
         if (xfer_ok && direct) begin
            cur_div <= cfg_div;
         end else if (xfer_ok) begin
            pend    <= cfg_div;
            pend_v  <= 1'b1;
         end else if (apply) begin
            cur_div <= pend;
            pend_v  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Randomized self-checking bench for clk_div_ctrl.
// A cycle-level behavioural model predicts every output after each edge.
module tb_clk_div_ctrl;

   localparam int W  = 16;
   localparam int DD = 4;

   localparam int M_IDLE  = 0;
   localparam int M_RUN   = 1;
   localparam int M_DRAIN = 2;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic         stop;
   logic         cfg_valid;
   logic [W-1:0] cfg_div;
   logic         cfg_ready;
   logic         cfg_err;
   logic         clk_out;
   logic         tick;
   logic         busy;
   logic [W-1:0] cur_div;

   int n_chk = 0;
   int n_err = 0;

   int m_mode;
   int m_pos;
   int m_lvl;
   int m_div;
   int m_tick;
   int m_err;
   int pend_q[$];

   clk_div_ctrl #(
      .WIDTH       (W),
      .DEFAULT_DIV (DD)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .stop      (stop),
      .cfg_valid (cfg_valid),
      .cfg_div   (cfg_div),
      .cfg_ready (cfg_ready),
      .cfg_err   (cfg_err),
      .clk_out   (clk_out),
      .tick      (tick),
      .busy      (busy),
      .cur_div   (cur_div)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag,
                        input logic [31:0] obs,
                        input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t",
                  tag, obs, exp, $time);
      end
   endtask

   // Reference: half-period position, output level, divisor in use and
   // a one-deep queue of divisors waiting for a half-period boundary.
   task automatic model(input bit r, input bit st, input bit sp,
                        input bit cv, input int cd);
      bit ready;
      bit xfer;
      bit active;
      bit toggle;
      int nxt;
      if (r) begin
         m_mode = M_IDLE;
         m_pos  = 0;
         m_lvl  = 0;
         m_tick = 0;
         m_err  = 0;
         m_div  = DD;
         pend_q.delete();
         return;
      end
      ready  = (pend_q.size() == 0);
      xfer   = cv && ready;
      active = (m_mode != M_IDLE) &&
               !(m_mode == M_RUN && sp && m_lvl == 0);
      toggle = active && (m_pos + 1 == m_div);
      nxt    = m_mode;
      if (m_mode == M_IDLE && st && !sp)
         nxt = M_RUN;
      else if (m_mode == M_RUN && sp)
         nxt = (m_lvl == 1 && !toggle) ? M_DRAIN : M_IDLE;
      else if (m_mode == M_DRAIN && st && !sp)
         nxt = M_RUN;
      else if (m_mode == M_DRAIN && toggle)
         nxt = M_IDLE;
      m_tick = toggle;
      m_err  = xfer && (cd == 0);
      if (xfer && cd != 0) begin
         if (m_mode == M_IDLE || nxt == M_IDLE) m_div = cd;
         else pend_q.push_back(cd);
      end else if (pend_q.size() > 0 && (toggle || nxt == M_IDLE)) begin
         m_div = pend_q.pop_front();
      end
      if (!active) begin
         m_pos = 0;
         m_lvl = 0;
      end else if (toggle) begin
         m_pos = 0;
         m_lvl = 1 - m_lvl;
      end else begin
         m_pos++;
      end
      m_mode = nxt;
   endtask

   task automatic step(input bit r, input bit st, input bit sp,
                       input bit cv, input int cd);
      rst       = r;
      start     = st;
      stop      = sp;
      cfg_valid = cv;
      cfg_div   = W'(cd);
      @(posedge clk);
      model(r, st, sp, cv, cd);
      #1;
      check("clk_out",   32'(clk_out),   32'(m_lvl));
      check("tick",      32'(tick),      32'(m_tick));
      check("busy",      32'(busy),      32'(m_mode != M_IDLE));
      check("cur_div",   32'(cur_div),   32'(m_div));
      check("cfg_ready", 32'(cfg_ready), 32'(pend_q.size() == 0));
      check("cfg_err",   32'(cfg_err),   32'(m_err));
   endtask

   initial begin
      bit r, st, sp, cv;
      int cd;
      rst = 1'b1;
      start = 1'b0;
      stop = 1'b0;
      cfg_valid = 1'b0;
      cfg_div = '0;

      step(1, 0, 0, 0, 0);
      step(1, 1, 0, 1, 3);
      check("rst_div",   32'(cur_div),   32'(DD));
      check("rst_ready", 32'(cfg_ready), 32'd1);
      check("rst_clk",   32'(clk_out),   32'd0);

      // first rising edge of clk_out four counts after start
      step(0, 1, 0, 0, 0);
      check("start_busy", 32'(busy), 32'd1);
      for (int i = 0; i < 3; i++) begin
         step(0, 0, 0, 0, 0);
         check("rise_early", 32'(clk_out), 32'd0);
      end
      step(0, 0, 0, 0, 0);
      check("rise",      32'(clk_out), 32'd1);
      check("rise_tick", 32'(tick),    32'd1);

      // divisor offered one cycle after a toggle waits for the boundary
      step(0, 0, 0, 1, 2);
      check("ready_drop", 32'(cfg_ready), 32'd0);
      check("div_hold",   32'(cur_div),   32'(DD));
      for (int i = 0; i < 20; i++) step(0, 0, 0, 0, 0);
      check("div_new",    32'(cur_div),   32'd2);

      step(0, 0, 1, 0, 0);
      for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0);
      check("stopped", 32'(busy), 32'd0);

      step(0, 0, 0, 1, 4);
      step(0, 0, 0, 1, 0);
      check("err_pulse", 32'(cfg_err), 32'd1);
      check("div_kept",  32'(cur_div), 32'd4);
      step(0, 0, 0, 0, 0);
      check("err_once",  32'(cfg_err), 32'd0);

      // reset while a divisor is pending
      step(0, 1, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 1, 6);
      check("pend_full", 32'(cfg_ready), 32'd0);
      step(1, 1, 0, 1, 5);
      check("mid_rst_div",   32'(cur_div),   32'(DD));
      check("mid_rst_ready", 32'(cfg_ready), 32'd1);
      check("mid_rst_busy",  32'(busy),      32'd0);

      for (int i = 0; i < 3000; i++) begin
         r  = ($urandom_range(0, 299) == 0);
         st = ($urandom_range(0, 3) == 0);
         sp = ($urandom_range(0, 11) == 0);
         cv = ($urandom_range(0, 3) == 0);
         cd = int'($urandom_range(0, 6));
         step(r, st, sp, cv, cd);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
